sparc_decode_alu_branch: RTL and testbench

// Core of the SPARC-subset 5-stage pipeline. It combines three functions:
// - ID-stage instruction decoder producing a 16-bit control word.
// - EX-stage 32-bit ALU with N/Z/V/C flags.
// - Processor-status CC register, plus branch-condition evaluation that drives the IF PC mux.

---
 rtl/sparc_decode_alu_branch.sv | 196 +++++++++++++++++++
 tb/tb_sparc_decode_alu_branch.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sparc_decode_alu_branch.sv
// SPARC-subset core slice: ID decoder, EX ALU with N/Z/V/C flags, PSR condition
// codes and Bicc condition evaluation with same-cycle flag forwarding.
module sparc_decode_alu_branch (
  input  logic        Clk,
  input  logic        R,
  input  logic [31:0] id_instr,
  output logic [15:0] ctrl,
  input  logic [3:0]  ex_alu_op,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic        ex_modify_cc,
  output logic [31:0] alu_out,
  output logic [3:0]  alu_flags,
  output logic [3:0]  psr_cc,
  output logic        cin,
  input  logic [3:0]  id_cond,
  input  logic        id_b_instr,
  output logic        branch_taken
);

  // ---------------- decode ----------------
  logic [1:0] op;
  logic [2:0] op2;
  logic [5:0] op3;
  logic       jmpl, rw, se_dm, load, rf_en, mod_cc, call, dm_en, b_ins, annul;
  logic [3:0] dec_alu_op;
  logic [1:0] size_dm;
  logic       hit;

  assign op  = id_instr[31:30];
  assign op2 = id_instr[24:22];
  assign op3 = id_instr[24:19];

  always_comb begin
    jmpl = 1'b0; rw = 1'b0; se_dm = 1'b0; load = 1'b0; rf_en = 1'b0;
    mod_cc = 1'b0; call = 1'b0; dm_en = 1'b0; b_ins = 1'b0; annul = 1'b0;
    dec_alu_op = 4'b0000; size_dm = 2'b00; hit = 1'b0;
    if (id_instr != 32'd0) begin
      unique case (op)
        2'b01: begin
          call  = 1'b1;
          rf_en = 1'b1;
        end
        2'b00: begin
          if (op2 == 3'b010) begin
            b_ins = 1'b1;
            annul = id_instr[29];
          end else if (op2 == 3'b100) begin
            dec_alu_op = 4'b1110;
            rf_en      = 1'b1;
          end
        end
        2'b10: begin
          if (op3 == 6'b111000) begin
            jmpl  = 1'b1;
            rf_en = 1'b1;
          end else if (!op3[5]) begin
            // op3[4] selects the cc-setting twin of each logical/arith op
            hit = 1'b1;
            case (op3[3:0])
              4'b0000: dec_alu_op = 4'b0000;
              4'b1000: dec_alu_op = 4'b0001;
              4'b0100: dec_alu_op = 4'b0010;
              4'b1100: dec_alu_op = 4'b0011;
              4'b0001: dec_alu_op = 4'b0100;
              4'b0010: dec_alu_op = 4'b0101;
              4'b0011: dec_alu_op = 4'b0110;
              4'b0111: dec_alu_op = 4'b0111;
              4'b0101: dec_alu_op = 4'b1000;
              4'b0110: dec_alu_op = 4'b1001;
              default: hit = 1'b0;
            endcase
            rf_en  = hit;
            mod_cc = hit & op3[4];
          end else begin
            hit = 1'b1;
            case (op3)
              6'b100101: dec_alu_op = 4'b1010;
              6'b100110: dec_alu_op = 4'b1011;
              6'b100111: dec_alu_op = 4'b1100;
              default:   hit = 1'b0;
            endcase
            rf_en = hit;
          end
        end
        2'b11: begin
          hit = 1'b1;
          case (op3)
            6'b000000: begin load = 1'b1; size_dm = 2'b10; end
            6'b000001: begin load = 1'b1; size_dm = 2'b00; end
            6'b000010: begin load = 1'b1; size_dm = 2'b01; end
            6'b001001: begin load = 1'b1; size_dm = 2'b00; se_dm = 1'b1; end
            6'b001010: begin load = 1'b1; size_dm = 2'b01; se_dm = 1'b1; end
            6'b000100: begin rw = 1'b1; size_dm = 2'b10; end
            6'b000101: begin rw = 1'b1; size_dm = 2'b00; end
            6'b000110: begin rw = 1'b1; size_dm = 2'b01; end
            default:   hit = 1'b0;
          endcase
          dm_en = hit;
          rf_en = load;
        end
        default: ;
      endcase
    end
  end

  assign ctrl = {jmpl, rw, dec_alu_op, se_dm, load, rf_en, size_dm,
                 mod_cc, call, dm_en, b_ins, annul};

  // ---------------- ALU ----------------
  logic [32:0] sum, dif;
  logic        is_add, is_sub, use_c;
  logic [31:0] res;
  logic        fc, fv;

  assign is_add = (ex_alu_op == 4'b0000) || (ex_alu_op == 4'b0001);
  assign is_sub = (ex_alu_op == 4'b0010) || (ex_alu_op == 4'b0011);
  assign use_c  = ex_alu_op[0] & cin;
  assign sum    = {1'b0, ex_a} + {1'b0, ex_b} + {32'd0, use_c};
  // bit 32 of the 33-bit difference is the unsigned borrow
  assign dif    = {1'b0, ex_a} - {1'b0, ex_b} - {32'd0, use_c};

  always_comb begin
    res = 32'd0;
    fc  = 1'b0;
    fv  = 1'b0;
    case (ex_alu_op)
      4'b0000, 4'b0001: res = sum[31:0];
      4'b0010, 4'b0011: res = dif[31:0];
      4'b0100: res = ex_a & ex_b;
      4'b0101: res = ex_a | ex_b;
      4'b0110: res = ex_a ^ ex_b;
      4'b0111: res = ~(ex_a ^ ex_b);
      4'b1000: res = ex_a & ~ex_b;
      4'b1001: res = ex_a | ~ex_b;
      4'b1010: res = ex_a << ex_b[4:0];
      4'b1011: res = ex_a >> ex_b[4:0];
      4'b1100: res = 32'($signed(ex_a) >>> ex_b[4:0]);
      4'b1101: res = ex_a;
      4'b1110: res = ex_b;
      default: res = ~ex_b;
    endcase
    if (is_add) begin
      fc = sum[32];
      fv = (ex_a[31] == ex_b[31]) && (res[31] != ex_a[31]);
    end else if (is_sub) begin
      fc = dif[32];
      fv = (ex_a[31] != ex_b[31]) && (res[31] != ex_a[31]);
    end
  end

  assign alu_out   = res;
  assign alu_flags = {res[31], (res == 32'd0), fv, fc};

  // ---------------- PSR condition codes ----------------
  logic [3:0] psr_cc_d, psr_cc_q;

  always_comb begin
    psr_cc_d = psr_cc_q;
    if (ex_modify_cc) psr_cc_d = alu_flags;
  end

  always_ff @(posedge Clk or negedge R) begin
    if (!R) psr_cc_q <= 4'b0000;
    else    psr_cc_q <= psr_cc_d;
  end

  assign psr_cc = psr_cc_q;
  assign cin    = psr_cc_q[0];

  // ---------------- branch condition ----------------
  logic [3:0] bf;
  logic       bn, bz, bv, bc, cond_true;

  assign bf = ex_modify_cc ? alu_flags : psr_cc_q;
  assign {bn, bz, bv, bc} = bf;

  always_comb begin
    cond_true = 1'b0;
    case (id_cond[2:0])
      3'b000: cond_true = 1'b0;
      3'b001: cond_true = bz;
      3'b010: cond_true = bz | (bn ^ bv);
      3'b011: cond_true = bn ^ bv;
      3'b100: cond_true = bc | bz;
      3'b101: cond_true = bc;
      3'b110: cond_true = bn;
      default: cond_true = bv;
    endcase
    // upper half of the cond space is the complement of the lower half
    if (id_cond[3]) cond_true = ~cond_true;
  end

  assign branch_taken = id_b_instr & cond_true;

endmodule

// File: tb/tb_sparc_decode_alu_branch.sv
// Bench for sparc_decode_alu_branch: decode/ALU vector tables, directed CC and
// reset sequences, and random ALU/branch traffic against an arithmetic model.
module tb_sparc_decode_alu_branch;
  logic        Clk = 1'b0;
  logic        R;
  logic [31:0] id_instr;
  logic [15:0] ctrl;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_a, ex_b;
  logic        ex_modify_cc;
  logic [31:0] alu_out;
  logic [3:0]  alu_flags, psr_cc;
  logic        cin;
  logic [3:0]  id_cond;
  logic        id_b_instr;
  logic        branch_taken;

  int checks = 0;
  int failures = 0;

  sparc_decode_alu_branch dut (
    .Clk(Clk), .R(R), .id_instr(id_instr), .ctrl(ctrl),
    .ex_alu_op(ex_alu_op), .ex_a(ex_a), .ex_b(ex_b), .ex_modify_cc(ex_modify_cc),
    .alu_out(alu_out), .alu_flags(alu_flags), .psr_cc(psr_cc), .cin(cin),
    .id_cond(id_cond), .id_b_instr(id_b_instr), .branch_taken(branch_taken)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ALU: plain unsigned/signed 64-bit arithmetic, returns {out, N,Z,V,C}
  function automatic logic [35:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic c);
    longint ua, ub, sa, sb, full, s;
    logic [31:0] r;
    logic v, cy;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    v = 1'b0; cy = 1'b0;
    case (op)
      4'd0, 4'd1: begin
        full = ua + ub + ((op == 4'd1) ? longint'(c) : 0);
        s    = sa + sb + ((op == 4'd1) ? longint'(c) : 0);
        r  = full[31:0];
        cy = full > 64'sh0_FFFF_FFFF;
        v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2, 4'd3: begin
        full = ua - ub - ((op == 4'd3) ? longint'(c) : 0);
        s    = sa - sb - ((op == 4'd3) ? longint'(c) : 0);
        r  = full[31:0];
        cy = full < 0;
        v  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4:  r = a & b;
      4'd5:  r = a | b;
      4'd6:  r = a ^ b;
      4'd7:  r = ~(a ^ b);
      4'd8:  r = a & ~b;
      4'd9:  r = a | ~b;
      4'd10: r = a << b[4:0];
      4'd11: r = a >> b[4:0];
      4'd12: r = 32'(sa >> b[4:0]);
      4'd13: r = a;
      4'd14: r = b;
      default: r = ~b;
    endcase
    return {r, r[31], (r == 32'd0), v, cy};
  endfunction

  function automatic logic m_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c;
    {n, z, v, c} = f;
    case (cond)
      4'd0:  return 1'b0;
      4'd1:  return z;
      4'd2:  return z | (n ^ v);
      4'd3:  return n ^ v;
      4'd4:  return c | z;
      4'd5:  return c;
      4'd6:  return n;
      4'd7:  return v;
      4'd8:  return 1'b1;
      4'd9:  return ~z;
      4'd10: return ~(z | (n ^ v));
      4'd11: return ~(n ^ v);
      4'd12: return ~(c | z);
      4'd13: return ~c;
      4'd14: return ~n;
      default: return ~v;
    endcase
  endfunction

  typedef struct { logic [31:0] instr; logic [15:0] ctrl; } dec_vec_t;
  typedef struct { logic [3:0] op; logic [31:0] a, b, out; logic [3:0] flags; } alu_vec_t;

  dec_vec_t dv[16];
  alu_vec_t av[8];
  logic [35:0] m;
  logic [3:0]  mpsr, used;

  initial begin
    dv[0]  = '{32'h00000000, 16'h0000}; // nop
    dv[1]  = '{32'h86A04002, 16'h0890}; // subcc
    dv[2]  = '{32'h82004003, 16'h0080}; // add
    dv[3]  = '{32'h82804003, 16'h0090}; // addcc
    dv[4]  = '{32'h83284003, 16'h2880}; // sll
    dv[5]  = '{32'h83384003, 16'h3080}; // sra
    dv[6]  = '{32'h81C04000, 16'h8080}; // jmpl
    dv[7]  = '{32'h40000010, 16'h0088}; // call
    dv[8]  = '{32'h30800004, 16'h0003}; // ba,a
    dv[9]  = '{32'h10800004, 16'h0002}; // ba
    dv[10] = '{32'h03000123, 16'h3880}; // sethi
    dv[11] = '{32'hC2080000, 16'h0184}; // ldub
    dv[12] = '{32'hC2500000, 16'h03A4}; // ldsh
    dv[13] = '{32'hC2200000, 16'h4044}; // st
    dv[14] = '{32'h82B80000, 16'h1C90}; // xnorcc
    dv[15] = '{32'h81F80000, 16'h0000}; // unlisted op3

    av[0] = '{4'd0,  32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1010};
    av[1] = '{4'd2,  32'd5, 32'd5, 32'd0, 4'b0100};
    av[2] = '{4'd12, 32'h80000000, 32'd4, 32'hF8000000, 4'b1000};
    av[3] = '{4'd2,  32'd3, 32'd5, 32'hFFFFFFFE, 4'b1001};
    av[4] = '{4'd0,  32'hFFFFFFFF, 32'h1, 32'h0, 4'b0101};
    av[5] = '{4'd11, 32'h80000000, 32'd31, 32'h1, 4'b0000};
    av[6] = '{4'd15, 32'h0, 32'hFFFFFFFF, 32'h0, 4'b0100};
    av[7] = '{4'd2,  32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0010};

    R = 1'b0; id_instr = '0; ex_alu_op = '0; ex_a = '0; ex_b = '0;
    ex_modify_cc = 1'b0; id_cond = '0; id_b_instr = 1'b0;
    #1;
    chk("reset_psr", 64'(psr_cc), 64'h0);
    chk("reset_cin", 64'(cin), 64'h0);
    @(posedge Clk); #1; R = 1'b1;

    for (int i = 0; i < 16; i++) begin
      id_instr = dv[i].instr; #1;
      chk($sformatf("dec_%0d", i), 64'(ctrl), 64'(dv[i].ctrl));
    end

    for (int i = 0; i < 8; i++) begin
      ex_alu_op = av[i].op; ex_a = av[i].a; ex_b = av[i].b; #1;
      chk($sformatf("alu_out_%0d", i), 64'(alu_out), 64'(av[i].out));
      chk($sformatf("alu_flags_%0d", i), 64'(alu_flags), 64'(av[i].flags));
    end

    // subcc 5-5 loads CC, then be is taken from the registered flags
    ex_alu_op = 4'd2; ex_a = 32'd5; ex_b = 32'd5; ex_modify_cc = 1'b1;
    @(posedge Clk); #1;
    chk("cc_after_subcc", 64'(psr_cc), 64'h4);
    ex_modify_cc = 1'b0; ex_alu_op = 4'd0; ex_b = 32'd1;
    id_cond = 4'd1; id_b_instr = 1'b1; #1;
    chk("be_from_psr", 64'(branch_taken), 64'h1);
    id_cond = 4'd9; #1;
    chk("bne_from_psr", 64'(branch_taken), 64'h0);

    // reset mid-cycle clears CC at once; ba still evaluates
    #2; R = 1'b0; #1;
    chk("async_reset_psr", 64'(psr_cc), 64'h0);
    id_cond = 4'd8; id_b_instr = 1'b1; #1;
    chk("ba_in_reset", 64'(branch_taken), 64'h1);
    id_b_instr = 1'b0; #1;
    chk("ba_no_binstr", 64'(branch_taken), 64'h0);
    id_cond = 4'd1; id_b_instr = 1'b1; #1;
    chk("be_in_reset", 64'(branch_taken), 64'h0);
    @(posedge Clk); #1; R = 1'b1;

    // forwarding: CC=0000 but the EX op sets Z in the same cycle
    ex_alu_op = 4'd2; ex_a = 32'd9; ex_b = 32'd9; ex_modify_cc = 1'b1;
    id_cond = 4'd1; id_b_instr = 1'b1; #1;
    chk("fwd_psr_before", 64'(psr_cc), 64'h0);
    chk("fwd_be", 64'(branch_taken), 64'h1);
    @(posedge Clk); #1;
    chk("fwd_psr_after", 64'(psr_cc), 64'h4);
    mpsr = 4'h4;

    // random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      ex_alu_op = 4'($urandom_range(15));
      ex_a = $urandom; ex_b = $urandom;
      case ($urandom_range(3))
        0: ex_b = ex_a;
        1: ex_a = 32'h7FFFFFFF + 32'($urandom_range(2));
        default: ;
      endcase
      ex_modify_cc = 1'($urandom);
      id_cond = 4'($urandom_range(15));
      id_b_instr = 1'($urandom);
      #3;
      m = m_alu(ex_alu_op, ex_a, ex_b, mpsr[0]);
      used = ex_modify_cc ? m[3:0] : mpsr;
      chk("rnd_cin", 64'(cin), 64'(mpsr[0]));
      chk("rnd_alu_out", 64'(alu_out), 64'(m[35:4]));
      chk("rnd_alu_flags", 64'(alu_flags), 64'(m[3:0]));
      chk("rnd_branch", 64'(branch_taken), 64'(id_b_instr & m_cond(id_cond, used)));
      @(posedge Clk); #1;
      if (ex_modify_cc) mpsr = m[3:0];
      chk("rnd_psr", 64'(psr_cc), 64'(mpsr));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
